// File: rtl/cpu_out_uart_tx_if.sv
// Write-side handshake between the core's output port and the UART transmit stage.
interface cpu_out_uart_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              out_valid;
    logic [DATA_W-1:0] cpu_out;
    logic              in_ready;

    modport master (
        output out_valid,
        output cpu_out,
        input  in_ready
    );

    modport slave (
        input  out_valid,
        input  cpu_out,
        output in_ready
    );
endinterface

// File: rtl/cpu_out_uart_tx.sv
// Buffers bytes from the core's output port in a small FIFO and sends each as an 8N1 UART frame.
// Back-to-back frames are contiguous; tx is registered and idles high.
module cpu_out_uart_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                               clkbar,
    input  logic                               resetbar,
    cpu_out_uart_tx_if.slave                   bus,
    output logic                               tx,
    output logic                               tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               overflow
);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW  = $clog2(DATA_W);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e              state_q, state_d;
    logic [BaudW-1:0]    baud_q, baud_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic push, pop, baud_last, in_ready;

    // No bypass: a full FIFO refuses a push even when a pop happens in the same cycle.
    assign in_ready     = (count_q != CntW'(FIFO_DEPTH));
    assign bus.in_ready = in_ready;
    assign push         = bus.out_valid && in_ready;
    assign baud_last    = (baud_q == BaudW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.out_valid & ~in_ready);
        pop        = 1'b0;

        case (state_q)
            StIdle: begin
                pop = (count_q != '0);
            end
            StStart: begin
                if (baud_last) begin
                    state_d = StData;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BitW'(DATA_W - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + BitW'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            state_d  = StStart;
            baud_d   = '0;
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // tx is computed from the next state so the line is registered with no extra lag.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clkbar) begin
        if (resetbar) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clkbar) begin
        if (push && !resetbar) begin
            mem_q[wr_ptr_q] <= bus.cpu_out;
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = (state_q != StIdle);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Directed bench: per-cycle vector table for reset and overflow, plus frame-level sequences
// checked by a serial receiver model on tx.
module tb_cpu_out_uart_tx;
    localparam int CPB = 4;

    logic       clk;
    logic       resetbar;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;
    logic       overflow;

    cpu_out_uart_tx_if #(.DATA_W(8)) bus ();

    cpu_out_uart_tx #(
        .DATA_W       (8),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clkbar     (clk),
        .resetbar   (resetbar),
        .bus        (bus),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: samples tx mid-bit, relative to the first low cycle of a frame.
    logic [7:0] rx_q[$];
    int         starts[$];
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = 8'h00;
    logic       mon_rst;

    always @(posedge clk) begin
        mon_rst = resetbar;
        #2;
        if (mon_rst) begin
            rx_active = 1'b0;
            rx_q.delete();
            starts.delete();
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                starts.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB + CPB / 2 && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
                rx_byte[rx_cnt / CPB - 1] = tx;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                check("rx_stop_bit", {31'd0, tx}, 32'd1);
                rx_q.push_back(rx_byte);
            end
            if (rx_cnt == 10 * CPB - 1) rx_active = 1'b0;
        end
    end

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) step();
        check("rx_frames", rx_q.size(), n);
    endtask

    task automatic expect_bytes(input string name, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() > 0) check(name, {24'd0, rx_q.pop_front()}, {24'd0, first + 8'(i)});
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.out_valid = 1'b1;
        bus.cpu_out   = b;
        step();
        bus.out_valid = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic       tx;
        logic       busy;
        logic [2:0] cnt;
        logic       rdy;
        logic       ovf;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [7:0] pat;
        logic       exp_tx;
        int         idx;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic       exp_tx;
        int         idx;

        resetbar      = 1'b1;
        bus.out_valid = 1'b0;
        bus.cpu_out   = 8'h00;

        // rst vld data   tx    busy  cnt   rdy   ovf
        vecs[0]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'hBB, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h15, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};

        #1;
        for (int i = 0; i < 11; i++) begin
            resetbar      = vecs[i].rst;
            bus.out_valid = vecs[i].vld;
            bus.cpu_out   = vecs[i].data;
            step();
            check($sformatf("vec%0d_tx", i), {31'd0, tx}, {31'd0, vecs[i].tx});
            check($sformatf("vec%0d_busy", i), {31'd0, tx_busy}, {31'd0, vecs[i].busy});
            check($sformatf("vec%0d_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].cnt});
            check($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].rdy});
            check($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
        end
        bus.out_valid = 1'b0;

        // Overflow tail: the five accepted bytes drain in order, 0x15 never appears.
        wait_rx(5, 5 * 10 * CPB + 20);
        expect_bytes("ovf_byte", 8'h10, 5);
        for (int i = 0; i < 3 * CPB; i++) step();
        check("ovf_extra_frames", rx_q.size(), 0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_drained_count", {29'd0, fifo_count}, 32'd0);

        resetbar = 1'b1;
        step();
        resetbar = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Single byte: exact per-cycle waveform of a 0xA5 frame.
        pat = 8'hA5;
        push_byte(pat);
        check("single_count_push", {29'd0, fifo_count}, 32'd1);
        check("single_tx_latency", {31'd0, tx}, 32'd1);
        for (int k = 1; k <= 10 * CPB; k++) begin
            step();
            idx = (k - 1) / CPB;
            if (idx == 0) exp_tx = 1'b0;
            else if (idx == 9) exp_tx = 1'b1;
            else exp_tx = pat[idx - 1];
            check($sformatf("single_tx_k%0d", k), {31'd0, tx}, {31'd0, exp_tx});
            check("single_busy", {31'd0, tx_busy}, 32'd1);
            if (k == 1) check("single_count_pop", {29'd0, fifo_count}, 32'd0);
        end
        step();
        check("single_busy_end", {31'd0, tx_busy}, 32'd0);
        check("single_tx_end", {31'd0, tx}, 32'd1);
        check("single_count_end", {29'd0, fifo_count}, 32'd0);
        wait_rx(1, 10);
        expect_bytes("single_byte", 8'hA5, 1);

        // Back-to-back: three contiguous frames.
        starts.delete();
        bus.out_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.cpu_out = 8'(i);
            step();
        end
        bus.out_valid = 1'b0;
        wait_rx(3, 3 * 10 * CPB + 20);
        expect_bytes("b2b_byte", 8'h01, 3);
        if (starts.size() == 3) begin
            check("b2b_gap1", starts[1] - starts[0], 10 * CPB);
            check("b2b_gap2", starts[2] - starts[1], 10 * CPB);
        end else begin
            check("b2b_starts", starts.size(), 3);
        end

        // Pointer wrap: nine bytes spaced one frame apart.
        for (int b = 0; b < 9; b++) begin
            push_byte(8'(b));
            check("wrap_count_max", {31'd0, fifo_count <= 3'd1}, 32'd1);
            for (int i = 1; i < 10 * CPB; i++) begin
                step();
                check("wrap_count_max", {31'd0, fifo_count <= 3'd1}, 32'd1);
            end
        end
        wait_rx(9, 2 * 10 * CPB);
        expect_bytes("wrap_byte", 8'h00, 9);

        // Reset mid-frame: 0xFF aborted in DATA, 0x55 discarded, 0x3C sent afterwards.
        push_byte(8'hFF);
        push_byte(8'h55);
        for (int i = 0; i < 12; i++) step();
        check("midrst_busy_before", {31'd0, tx_busy}, 32'd1);
        resetbar = 1'b1;
        step();
        resetbar = 1'b0;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_count", {29'd0, fifo_count}, 32'd0);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 15 * CPB; i++) step();
        check("midrst_no_frame", rx_q.size(), 0);
        check("midrst_tx_idle", {31'd0, tx}, 32'd1);
        push_byte(8'h3C);
        wait_rx(1, 10 * CPB + 20);
        expect_bytes("midrst_fresh", 8'h3C, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_out_uart_tx.md
Name: cpu_out_uart_tx

Overview:
Serial output stage directly downstream of the RISC_V core. It consumes the core's 8-bit cpu_out port on a write strobe, buffers bytes in a small FIFO, and transmits each byte as a UART frame (8N1) on a single tx line. This lets the core's output be observed on a pin or bench monitor without stalling the core.

Parameters:
DATA_W, 8, width of cpu_out and of each UART data field
FIFO_DEPTH, 4, number of buffered bytes; power of two, >= 2
CLKS_PER_BIT, 4, clkbar cycles per UART bit; >= 2

Ports:
clkbar  input  1  system clock; all state updates on its rising edge
resetbar  input  1  synchronous, active-high reset (high = reset, despite the name)
out_valid  input  1  one-cycle write strobe from the core: cpu_out holds a new byte
cpu_out  input  DATA_W  byte from the core's output port
in_ready  output  1  high when the FIFO is not full
tx  output  1  UART serial line, idle high
tx_busy  output  1  high while a frame is in progress (any state except IDLE)
fifo_count  output  $clog2(FIFO_DEPTH+1)  current number of buffered bytes
overflow  output  1  sticky: set when a byte is dropped because the FIFO is full

Behaviour:
- Reset: resetbar sampled high at a rising edge -> next cycle tx=1, tx_busy=0, fifo_count=0, in_ready=1, overflow=0, FSM=IDLE, read/write pointers=0. Reset takes priority over every other event, including a frame in progress, which is aborted with no partial stop bit.
- Push: out_valid && in_ready at an edge writes cpu_out at wr_ptr. wr_ptr increments modulo FIFO_DEPTH.
- Drop: out_valid && !in_ready -> byte discarded, overflow set. overflow stays set until reset.
- in_ready = (fifo_count != FIFO_DEPTH). It is combinational from the registered count. There is no bypass: a pop in the same cycle does not make room for a push when the FIFO is full.
- Pop: FSM in IDLE, or finishing STOP, with fifo_count != 0 -> loads the shift register from rd_ptr and rd_ptr increments modulo FIFO_DEPTH.
- Simultaneous push and pop with the FIFO not full -> fifo_count unchanged, and both operations take effect.
- FSM states:
  - IDLE: tx=1. Goes to START on a pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A bit index counts 0..DATA_W-1. After the last bit, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, pop again and go to START if the FIFO is non-empty (no idle gap); otherwise go to IDLE.
- Timing: one baud counter counts 0..CLKS_PER_BIT-1, is reset on every state or bit change, and wraps to 0.
- Latency: a push at edge N into an empty, idle block -> pop at edge N+1 -> tx goes low from edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- tx, tx_busy, and fifo_count are registered outputs, with no combinational path from out_valid.

Test Plan:
- Reset: hold resetbar=1 for 2 edges with out_valid toggling -> tx=1, tx_busy=0, fifo_count=0, in_ready=1, overflow=0, and nothing is pushed.
- Single byte: push 0xA5 at edge N (CLKS_PER_BIT=4) -> tx low over edges N+1..N+4; bits 1,0,1,0,0,1,0,1 for 4 cycles each; stop high for 4 cycles; tx_busy=0 after 40 cycles; fifo_count returns to 0.
- Back-to-back: push 0x01, 0x02, 0x03 on consecutive edges -> three contiguous 40-cycle frames with no idle cycle between them; receiver model decodes 0x01, 0x02, 0x03 in order.
- Overflow: push 0x10..0x15 on 6 consecutive edges starting idle -> 0x10..0x14 accepted (the first is popped at the 2nd edge); 0x15 dropped; in_ready=0 at the 6th edge; overflow=1 and stays 1; the five accepted bytes are transmitted in order.
- Pointer wrap: push 9 bytes spaced 40 cycles apart (0x00..0x08) -> all 9 are transmitted correctly across pointer wrap; fifo_count never exceeds 1.
- Reset mid-frame: push 0xFF, push 0x55, assert resetbar during DATA of the first frame -> tx=1 next cycle, fifo_count=0, 0x55 is never transmitted, and a fresh push of 0x3C afterwards transmits normally.
